// File: rtl/ram_obi_arbiter.sv
// rtl/ram_obi_arbiter.sv - two-master OBI front end for a single-port 1-cycle-latency RAM
//
// Purpose: arbitrates instruction fetch (m0) and data (m1) onto one RAM port,
// decodes the RAM address window, and routes each response to its issuer.
// Out-of-window accesses never reach the RAM and get a local error response.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mX_req/gnt               address phase handshake, X = 0 (fetch), 1 (data)
//   mX_addr/we/be/wdata      address phase payload
//   mX_rvalid/rdata/err      response phase, one cycle after gnt
//   ram_req/we/addr/be/wdata RAM command, ram_addr is the offset from ADDR_BASE
//   ram_rdata/ram_rvalid     RAM response, one cycle after ram_req
//   proto_err                sticky, RAM response missing or unexpected
module ram_obi_arbiter #(
  parameter int unsigned     AW         = 32,
  parameter logic [AW-1:0]   ADDR_BASE  = {AW{1'b0}},
  parameter int unsigned     DEPTH      = 128,
  parameter bit              FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_req,
  output logic          m0_gnt,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_we,
  input  logic [3:0]    m0_be,
  input  logic [31:0]   m0_wdata,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  output logic          m0_err,

  input  logic          m1_req,
  output logic          m1_gnt,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_we,
  input  logic [3:0]    m1_be,
  input  logic [31:0]   m1_wdata,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          m1_err,

  output logic          ram_req,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [3:0]    ram_be,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  input  logic          ram_rvalid,

  output logic          proto_err
);

  // Window bounds carried in AW+1 bits so a window ending at the top of the
  // address space does not wrap the upper bound to zero.
  localparam int unsigned AW1    = AW + 1;
  localparam logic [AW:0] WIN_LO = {1'b0, ADDR_BASE};
  localparam logic [AW:0] WIN_HI = WIN_LO + AW1'(4 * DEPTH);

  logic        rr_ptr;    // master preferred on the next contention cycle
  logic        resp_v;
  logic        resp_id;
  logic        resp_err;
  logic        resp_we;

  logic        gnt0;
  logic        gnt1;
  logic        acc;
  logic        contend;
  logic [AW-1:0] sel_addr;
  logic [AW:0]   sel_addr_x;
  logic        sel_we;
  logic        in_win;
  logic        rsp_fire;
  logic [31:0] rsp_data;

  assign contend = m0_req & m1_req;

  // Same-cycle arbitration; nothing is granted while in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (contend) begin
        if (FIXED_PRIO || rr_ptr) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
  end

  assign acc    = gnt0 | gnt1;
  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  assign sel_addr   = gnt1 ? m1_addr : m0_addr;
  assign sel_we     = gnt1 ? m1_we   : m0_we;
  assign sel_addr_x = {1'b0, sel_addr};
  assign in_win     = (sel_addr_x >= WIN_LO) && (sel_addr_x < WIN_HI);

  // RAM command follows the granted master and is all-zero without a grant.
  assign ram_req   = acc & in_win;
  assign ram_we    = acc & sel_we;
  assign ram_addr  = acc ? (sel_addr - ADDR_BASE) : {AW{1'b0}};
  assign ram_be    = gnt1 ? m1_be : (gnt0 ? m0_be : 4'b0000);
  assign ram_wdata = gnt1 ? m1_wdata : (gnt0 ? m0_wdata : 32'h0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= 1'b0;
      resp_v    <= 1'b0;
      resp_id   <= 1'b0;
      resp_err  <= 1'b0;
      resp_we   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      // Pointer moves only when both masters competed, so the loser is
      // first in line on the very next cycle.
      if (!FIXED_PRIO && contend) begin
        rr_ptr <= ~rr_ptr;
      end
      resp_v <= acc;
      if (acc) begin
        resp_id  <= gnt1;
        resp_err <= ~in_win;
        resp_we  <= sel_we;
      end
      // Error responses are generated locally, so only in-window responses
      // expect a RAM strobe; anything else from the RAM is a protocol fault.
      if ((resp_v && !resp_err && !ram_rvalid) ||
          (ram_rvalid && !(resp_v && !resp_err))) begin
        proto_err <= 1'b1;
      end
    end
  end

  // Gating with rst drops a response that was pending when reset arrived.
  assign rsp_fire = resp_v & ~rst;
  assign rsp_data = (!resp_err && !resp_we) ? ram_rdata : 32'h0;

  assign m0_rvalid = rsp_fire & ~resp_id;
  assign m1_rvalid = rsp_fire &  resp_id;
  assign m0_err    = m0_rvalid & resp_err;
  assign m1_err    = m1_rvalid & resp_err;
  assign m0_rdata  = m0_rvalid ? rsp_data : 32'h0;
  assign m1_rdata  = m1_rvalid ? rsp_data : 32'h0;

endmodule

// File: tb/tb_ram_obi_arbiter.sv
// tb/tb_ram_obi_arbiter.sv - self-checking bench for ram_obi_arbiter
module tb_ram_obi_arbiter;

  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          DEPTH  = 128;
  localparam logic [31:0] FBASE  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic        m0_we = 1'b0, m1_we = 1'b0;
  logic [3:0]  m0_be = 4'hF, m1_be = 4'hF;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_req, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [3:0]  ram_be;
  logic [31:0] ram_rdata = '0;
  logic        ram_rvalid = 1'b0;
  logic        proto_err;
  logic        drop_rvalid = 1'b0;

  logic        f_m0_gnt, f_m1_gnt, f_m0_rvalid, f_m1_rvalid, f_m0_err, f_m1_err;
  logic [31:0] f_m0_rdata, f_m1_rdata;
  logic        f_ram_req, f_ram_we, f_proto_err;
  logic [31:0] f_ram_addr, f_ram_wdata;
  logic [3:0]  f_ram_be;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram_obi_arbiter #(.AW(32), .ADDR_BASE(BASE), .DEPTH(DEPTH), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be),
    .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be),
    .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_be(ram_be),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_rvalid(ram_rvalid),
    .proto_err(proto_err)
  );

  ram_obi_arbiter #(.AW(32), .ADDR_BASE(FBASE), .DEPTH(DEPTH), .FIXED_PRIO(1'b1)) dut_fix (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_gnt(f_m0_gnt), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be),
    .m0_wdata(m0_wdata), .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata), .m0_err(f_m0_err),
    .m1_req(m1_req), .m1_gnt(f_m1_gnt), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be),
    .m1_wdata(m1_wdata), .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata), .m1_err(f_m1_err),
    .ram_req(f_ram_req), .ram_we(f_ram_we), .ram_addr(f_ram_addr), .ram_be(f_ram_be),
    .ram_wdata(f_ram_wdata), .ram_rdata(ram_rdata), .ram_rvalid(ram_rvalid),
    .proto_err(f_proto_err)
  );

  // RAM attached to the main instance; drop_rvalid suppresses the strobe.
  logic [31:0] ram_mem [0:DEPTH-1];
  always @(posedge clk) begin
    ram_rvalid <= ram_req && !drop_rvalid;
    if (ram_req) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) ram_mem[ram_addr[8:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= ram_mem[ram_addr[8:2]];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue-free one-deep view of "what was accepted last
  // cycle", a turn token for contention, and a copy of memory contents.
  logic [31:0] m_mem [0:DEPTH-1];
  bit          m_turn = 1'b0;   // master that wins the next contention
  bit          p_v = 1'b0, p_id = 1'b0, p_err = 1'b0;
  logic [31:0] p_rdata = '0;
  bit          m_proto = 1'b0;

  always @(negedge clk) begin : model
    bit          g0, g1, g, win, e_we, r0, r1;
    logic [31:0] e_addr, e_off, e_wd;
    logic [3:0]  e_be;
    longint      a;
    g0 = 1'b0; g1 = 1'b0;
    if (!rst) begin
      if (m0_req && m1_req) begin
        g1 = m_turn; g0 = !m_turn;
      end else begin
        g0 = m0_req; g1 = m1_req;
      end
    end
    g      = g0 || g1;
    e_addr = g1 ? m1_addr : m0_addr;
    e_we   = g1 ? m1_we : m0_we;
    e_be   = g1 ? m1_be : m0_be;
    e_wd   = g1 ? m1_wdata : m0_wdata;
    a      = longint'(e_addr);
    win    = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
    e_off  = e_addr - BASE;

    chk("m0_gnt", m0_gnt, g0);
    chk("m1_gnt", m1_gnt, g1);
    chk("ram_req", ram_req, g && win);
    chk("ram_we", ram_we, g && e_we);
    chk("ram_be", ram_be, g ? e_be : 4'h0);
    chk("ram_wdata", ram_wdata, g ? e_wd : 32'h0);
    chk("ram_addr", ram_addr, g ? e_off : 32'h0);

    r0 = !rst && p_v && !p_id;
    r1 = !rst && p_v && p_id;
    chk("m0_rvalid", m0_rvalid, r0);
    chk("m1_rvalid", m1_rvalid, r1);
    chk("m0_err", m0_err, r0 && p_err);
    chk("m1_err", m1_err, r1 && p_err);
    chk("m0_rdata", m0_rdata, r0 ? p_rdata : 32'h0);
    chk("m1_rdata", m1_rdata, r1 ? p_rdata : 32'h0);
    chk("proto_err", proto_err, m_proto);

    if (rst) begin
      m_turn = 1'b0; p_v = 1'b0; p_id = 1'b0; p_err = 1'b0; m_proto = 1'b0;
    end else begin
      if ((p_v && !p_err && !ram_rvalid) || (ram_rvalid && !(p_v && !p_err))) m_proto = 1'b1;
      if (m0_req && m1_req) m_turn = g0;  // the loser goes first next time
      p_v     = g;
      p_id    = g1;
      p_err   = !win;
      p_rdata = (g && win && !e_we) ? m_mem[e_off[8:2]] : 32'h0;
      if (g && win && e_we)
        for (int b = 0; b < 4; b++)
          if (e_be[b]) m_mem[e_off[8:2]][8*b +: 8] = e_wd[8*b +: 8];
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input bit r, input logic [31:0] a, input bit w,
                      input logic [3:0] be, input logic [31:0] wd);
    m0_req = r; m0_addr = a; m0_we = w; m0_be = be; m0_wdata = wd;
  endtask

  task automatic set1(input bit r, input logic [31:0] a, input bit w,
                      input logic [3:0] be, input logic [31:0] wd);
    m1_req = r; m1_addr = a; m1_we = w; m1_be = be; m1_wdata = wd;
  endtask

  task automatic vec(input bit r0, input logic [31:0] a0, input bit w0,
                     input bit r1, input logic [31:0] a1, input bit w1);
    set0(r0, a0, w0, 4'b0011, 32'hC0DE_0000 ^ a0);
    set1(r1, a1, w1, 4'b1100, 32'hFACE_0000 ^ a1);
    @(negedge clk);
    nxt();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = 32'hA5A5_0000 + i;
      m_mem[i]   = 32'hA5A5_0000 + i;
    end
    ram_mem[4] = 32'hDEAD_BEEF; m_mem[4] = 32'hDEAD_BEEF;
    ram_mem[8] = 32'h1122_3344; m_mem[8] = 32'h1122_3344;

    // Reset with both masters requesting
    rst = 1'b1;
    set0(1, 32'h10, 0, 4'hF, 0);
    set1(1, 32'h20, 0, 4'hF, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_m0_gnt", m0_gnt, 1'b0);
      chk("rst_m1_gnt", m1_gnt, 1'b0);
      chk("rst_ram_req", ram_req, 1'b0);
      chk("rst_f_m1_gnt", f_m1_gnt, 1'b0);
    end
    nxt();
    rst = 1'b0;

    // Contention for four cycles
    @(negedge clk);
    chk("c0_m0_gnt", m0_gnt, 1'b1);
    chk("c0_ram_addr", ram_addr, 32'h10);
    chk("c0_f_m1_gnt", f_m1_gnt, 1'b1);
    nxt();
    @(negedge clk);
    chk("c1_m1_gnt", m1_gnt, 1'b1);
    chk("c1_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("c1_f_m1_gnt", f_m1_gnt, 1'b1);
    nxt();
    @(negedge clk);
    chk("c2_m0_gnt", m0_gnt, 1'b1);
    chk("c2_m1_rdata", m1_rdata, 32'h1122_3344);
    chk("c2_f_m1_gnt", f_m1_gnt, 1'b1);
    nxt();
    @(negedge clk);
    chk("c3_m1_gnt", m1_gnt, 1'b1);
    chk("c3_m0_rvalid", m0_rvalid, 1'b1);
    chk("c3_f_m1_gnt", f_m1_gnt, 1'b1);
    chk("c3_f_m0_gnt", f_m0_gnt, 1'b0);
    nxt();
    set0(0, 0, 0, 4'hF, 0);
    set1(0, 0, 0, 4'hF, 0);
    @(negedge clk);
    chk("c4_m1_rvalid", m1_rvalid, 1'b1);
    nxt();

    // Single read by m0
    set0(1, 32'h10, 0, 4'hF, 0);
    @(negedge clk);
    chk("sr_m0_gnt", m0_gnt, 1'b1);
    chk("sr_ram_addr", ram_addr, 32'h10);
    nxt();
    set0(0, 0, 0, 4'hF, 0);
    @(negedge clk);
    chk("sr_m0_rvalid", m0_rvalid, 1'b1);
    chk("sr_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("sr_m0_err", m0_err, 1'b0);
    nxt();

    // Byte write then read back by m1
    set1(1, 32'h20, 1, 4'b0100, 32'h00AB_0000);
    @(negedge clk);
    chk("bw_ram_be", ram_be, 4'b0100);
    nxt();
    set1(1, 32'h20, 0, 4'hF, 0);
    @(negedge clk);
    chk("bw_m1_rvalid", m1_rvalid, 1'b1);
    chk("bw_m1_rdata", m1_rdata, 32'h0);
    nxt();
    set1(0, 0, 0, 4'hF, 0);
    @(negedge clk);
    chk("br_m1_rdata", m1_rdata, 32'h11AB_3344);
    nxt();

    // Out-of-window, then last in-window word
    set1(1, BASE + 4 * DEPTH, 0, 4'hF, 0);
    @(negedge clk);
    chk("oow_ram_req", ram_req, 1'b0);
    chk("oow_m1_gnt", m1_gnt, 1'b1);
    nxt();
    set1(0, 0, 0, 4'hF, 0);
    set0(1, BASE + 4 * DEPTH - 4, 0, 4'hF, 0);
    @(negedge clk);
    chk("oow_m1_err", m1_err, 1'b1);
    chk("oow_m1_rdata", m1_rdata, 32'h0);
    chk("top_ram_req", ram_req, 1'b1);
    nxt();
    set0(0, 0, 0, 4'hF, 0);
    @(negedge clk);
    chk("top_m0_rdata", m0_rdata, 32'hA5A5_007F);
    chk("oow_proto", proto_err, 1'b0);
    nxt();

    // Offset subtraction in the non-zero-base instance
    set1(1, 32'h120, 0, 4'hF, 0);
    @(negedge clk);
    chk("fb_ram_addr", f_ram_addr, 32'h20);
    chk("fb_ram_req", f_ram_req, 1'b1);
    nxt();
    set1(0, 0, 0, 4'hF, 0);

    // Mixed traffic checked by the model
    vec(1, 32'h40, 1, 1, 32'h44, 0);
    vec(1, 32'h40, 0, 1, 32'h44, 1);
    vec(1, 32'h44, 0, 0, 32'h0,  0);
    vec(0, 32'h0,  0, 1, 32'h40, 0);
    vec(1, 32'h300, 0, 1, 32'h48, 1);
    vec(1, 32'h48, 0, 1, 32'h300, 1);
    vec(1, 32'h4C, 1, 1, 32'h48, 0);
    vec(1, 32'h4C, 0, 0, 32'h0,  0);
    vec(1, 32'h4C, 0, 1, 32'h4C, 0);
    vec(0, 32'h0,  0, 1, 32'h1FC, 1);
    vec(1, 32'h1FC, 0, 1, 32'h1FC, 0);
    vec(0, 32'h0,  0, 0, 32'h0,  0);

    // Reset right after an acceptance drops the response
    set0(1, 32'h10, 0, 4'hF, 0);
    @(negedge clk);
    nxt();
    set0(0, 0, 0, 4'hF, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_m0_rvalid", m0_rvalid, 1'b0);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_m0_rvalid2", m0_rvalid, 1'b0);
    nxt();

    // Missing RAM strobe sets the sticky protocol error
    set0(1, 32'h10, 0, 4'hF, 0);
    drop_rvalid = 1'b1;
    @(negedge clk);
    nxt();
    set0(0, 0, 0, 4'hF, 0);
    drop_rvalid = 1'b0;
    @(negedge clk);
    chk("pe_before", proto_err, 1'b0);
    nxt();
    repeat (3) begin
      @(negedge clk);
      chk("pe_sticky", proto_err, 1'b1);
      nxt();
    end
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("pe_cleared", proto_err, 1'b0);
    nxt();
    repeat (2) nxt();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
